// File: rtl/chronometer_controller.sv
// Run/pause/lap/clear sequencer: debounces the front-panel buttons, gates the
// 100 Hz tick into the BCD chain, and drives the display page select.
module chronometer_controller #(
  parameter int unsigned DEBOUNCE_TICKS = 2,
  parameter int unsigned PAGE_TICKS     = 200
) (
  input  logic       clk_50m_i,
  input  logic       rst_n_i,
  input  logic       tick_100hz_i,
  input  logic       btn_start_stop_i,
  input  logic       btn_lap_i,
  input  logic       btn_clear_i,
  input  logic       auto_page_i,
  input  logic       manual_sel_i,
  output logic       tick_out_o,
  output logic       count_clr_o,
  output logic       lap_freeze_o,
  output logic       disp_sel_o,
  output logic [1:0] state_o
);

  localparam int unsigned DB_W   = 4;
  localparam int unsigned PAGE_W = 10;
  localparam int unsigned NBTN   = 3;
  localparam int unsigned BTN_SS  = 0;
  localparam int unsigned BTN_LAP = 1;
  localparam int unsigned BTN_CLR = 2;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  logic [NBTN-1:0]           btn_raw;
  logic [NBTN-1:0]           sync1_q, sync2_q;
  logic [NBTN-1:0]           level_q, level_d;
  logic [NBTN-1:0]           armed_q, armed_d;
  logic [NBTN-1:0]           press_q, press_d;
  logic [NBTN-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]                settle_q, settle_d;

  logic [1:0]        state_q, state_d;
  logic              count_clr_q, count_clr_d;
  logic              tick_out_q, tick_out_d;
  logic              lap_freeze_q, lap_freeze_d;
  logic [PAGE_W-1:0] page_cnt_q, page_cnt_d;
  logic              disp_sel_q, disp_sel_d;

  assign btn_raw = {btn_clear_i, btn_lap_i, btn_start_stop_i};

  // Debounce on ticks; a button only arms once it has been seen released after
  // reset (settle_q==2 marks the synchronizer as flushed), so a held button
  // cannot fire an event coming out of reset.
  always_comb begin
    level_d  = level_q;
    armed_d  = armed_q;
    db_cnt_d = db_cnt_q;
    press_d  = '0;
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    for (int i = 0; i < int'(NBTN); i++) begin
      if (tick_100hz_i) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_d[i] = '0;
        end else if (db_cnt_q[i] + DB_W'(1) == DB_W'(DEBOUNCE_TICKS)) begin
          level_d[i]  = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
        if ((settle_q == 2'd2) && !sync2_q[i]) begin
          armed_d[i] = 1'b1;
        end
      end
      press_d[i] = level_d[i] & ~level_q[i] & armed_q[i];
    end
  end

  // Sequencer: clear > start_stop > lap, only the top legal event is taken.
  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_q[BTN_CLR])     count_clr_d = 1'b1;
        else if (press_q[BTN_SS]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press_q[BTN_SS])       state_d = ST_PAUSE;
        else if (press_q[BTN_LAP]) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (press_q[BTN_SS])       state_d = ST_PAUSE;
        else if (press_q[BTN_LAP]) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (press_q[BTN_CLR]) begin
          count_clr_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (press_q[BTN_SS]) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tick_out_d   = tick_100hz_i & ((state_q == ST_RUN) || (state_q == ST_LAP));
    lap_freeze_d = (state_d == ST_LAP);
  end

  always_comb begin
    page_cnt_d = page_cnt_q;
    disp_sel_d = disp_sel_q;
    if (!auto_page_i) begin
      page_cnt_d = '0;
      disp_sel_d = manual_sel_i;
    end else if (tick_100hz_i) begin
      if (page_cnt_q == PAGE_W'(PAGE_TICKS - 1)) begin
        page_cnt_d = '0;
        disp_sel_d = ~disp_sel_q;
      end else begin
        page_cnt_d = page_cnt_q + PAGE_W'(1);
      end
    end
  end

  // COUNT_CLR resets high: the counter chain has no reset of its own.
  always_ff @(posedge clk_50m_i) begin
    if (!rst_n_i) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      armed_q      <= '0;
      press_q      <= '0;
      db_cnt_q     <= '0;
      settle_q     <= '0;
      state_q      <= ST_IDLE;
      count_clr_q  <= 1'b1;
      tick_out_q   <= 1'b0;
      lap_freeze_q <= 1'b0;
      page_cnt_q   <= '0;
      disp_sel_q   <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      armed_q      <= armed_d;
      press_q      <= press_d;
      db_cnt_q     <= db_cnt_d;
      settle_q     <= settle_d;
      state_q      <= state_d;
      count_clr_q  <= count_clr_d;
      tick_out_q   <= tick_out_d;
      lap_freeze_q <= lap_freeze_d;
      page_cnt_q   <= page_cnt_d;
      disp_sel_q   <= disp_sel_d;
    end
  end

  assign tick_out_o   = tick_out_q;
  assign count_clr_o  = count_clr_q;
  assign lap_freeze_o = lap_freeze_q;
  assign disp_sel_o   = disp_sel_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_chronometer_controller.sv
// Directed bench for chronometer_controller: button sequencing, tick gating,
// clear priority, page select and reset with a held button.
module tb_chronometer_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] btns = 3'b000;  // {clear, lap, start_stop}
  logic       auto_page = 1'b0;
  logic       manual_sel = 1'b0;
  logic       tick_out, count_clr, lap_freeze, disp_sel;
  logic [1:0] state;

  int n_chk = 0;
  int n_bad = 0;
  int overlap = 0;

  localparam logic [2:0] B_SS  = 3'b001;
  localparam logic [2:0] B_LAP = 3'b010;
  localparam logic [2:0] B_CLR = 3'b100;

  chronometer_controller #(.DEBOUNCE_TICKS(2), .PAGE_TICKS(4)) dut (
    .clk_50m_i       (clk),
    .rst_n_i         (rst_n),
    .tick_100hz_i    (tick),
    .btn_start_stop_i(btns[0]),
    .btn_lap_i       (btns[1]),
    .btn_clear_i     (btns[2]),
    .auto_page_i     (auto_page),
    .manual_sel_i    (manual_sel),
    .tick_out_o      (tick_out),
    .count_clr_o     (count_clr),
    .lap_freeze_o    (lap_freeze),
    .disp_sel_o      (disp_sel),
    .state_o         (state)
  );

  always #5 clk = ~clk;

  // One-cycle tick every 10 clocks.
  initial begin
    forever begin
      repeat (9) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  always @(negedge clk) if (tick_out && count_clr) overlap++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Hold the masked buttons, release them, then let the release debounce.
  task automatic press(input logic [2:0] mask);
    @(negedge clk);
    btns = btns | mask;
    repeat (40) @(negedge clk);
    btns = btns & ~mask;
    repeat (40) @(negedge clk);
  endtask

  task automatic run_win(input int n, output int tk, output int cc, output int fz);
    tk = 0; cc = 0; fz = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tick_out)   tk++;
      if (count_clr)  cc++;
      if (lap_freeze) fz++;
    end
  endtask

  task automatic tick_latency();
    int found;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (tick) found = 1;
    end
    chk("tick_seen", found, 1);
    chk("tick_out_before", int'(tick_out), 0);
    @(negedge clk);
    chk("tick_out_after", int'(tick_out), 1);
  endtask

  initial begin
    int tk, cc, fz, found, cyc;
    logic prev;

    // Reset and release
    repeat (5) @(negedge clk);
    chk("rst_count_clr", int'(count_clr), 1);
    chk("rst_state", int'(state), 0);
    chk("rst_tick_out", int'(tick_out), 0);
    chk("rst_lap_freeze", int'(lap_freeze), 0);
    chk("rst_disp_sel", int'(disp_sel), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_after_release", int'(count_clr), 0);
    run_win(100, tk, cc, fz);
    chk("idle_tick_out", tk, 0);
    chk("idle_state", int'(state), 0);

    // Start, then pause
    press(B_SS);
    chk("run_state", int'(state), 1);
    tick_latency();
    run_win(50, tk, cc, fz);
    chk("run_ticks", tk, 5);
    press(B_SS);
    chk("pause_state", int'(state), 2);
    run_win(50, tk, cc, fz);
    chk("pause_ticks", tk, 0);

    // Resume, lap glitch, lap, unlap
    press(B_SS);
    chk("resume_state", int'(state), 1);
    @(negedge clk);
    btns = btns | B_LAP;
    repeat (3) @(negedge clk);
    btns = btns & ~B_LAP;
    repeat (40) @(negedge clk);
    chk("glitch_state", int'(state), 1);
    press(B_LAP);
    chk("lap_state", int'(state), 3);
    run_win(50, tk, cc, fz);
    chk("lap_ticks", tk, 5);
    chk("lap_freeze", fz, 50);
    tick_latency();
    press(B_LAP);
    chk("unlap_state", int'(state), 1);
    chk("unlap_freeze", int'(lap_freeze), 0);

    // Start_stop + clear together: RUNNING then PAUSED
    @(negedge clk);
    btns = B_SS | B_CLR;
    run_win(40, tk, cc, fz);
    btns = 3'b000;
    chk("run_combo_state", int'(state), 2);
    chk("run_combo_clr", cc, 0);
    repeat (40) @(negedge clk);
    @(negedge clk);
    btns = B_SS | B_CLR;
    run_win(40, tk, cc, fz);
    btns = 3'b000;
    chk("pause_combo_state", int'(state), 0);
    chk("pause_combo_clr", cc, 1);
    repeat (40) @(negedge clk);
    press(B_CLR);
    chk("idle_clear_state", int'(state), 0);

    // Auto page, then back to manual
    @(negedge clk);
    auto_page = 1'b1;
    prev = disp_sel;
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      @(negedge clk);
      if (disp_sel != prev) found = 1;
    end
    chk("page_toggle_seen", found, 1);
    chk("page_first_val", int'(disp_sel), 1);
    prev = disp_sel;
    cyc = 0;
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      @(negedge clk);
      cyc++;
      if (disp_sel != prev) found = 1;
    end
    chk("page_period", cyc, 40);
    chk("page_second_val", int'(disp_sel), 0);
    manual_sel = 1'b1;
    auto_page  = 1'b0;
    @(negedge clk);
    chk("manual_sel_1", int'(disp_sel), 1);
    chk("page_cnt_zero", int'(dut.page_cnt_q), 0);
    manual_sel = 1'b0;
    @(negedge clk);
    chk("manual_sel_0", int'(disp_sel), 0);

    // Reset while in LAP with lap held
    press(B_SS);
    chk("pre_lap_run", int'(state), 1);
    @(negedge clk);
    btns = btns | B_LAP;
    repeat (40) @(negedge clk);
    chk("held_lap_state", int'(state), 3);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst2_state", int'(state), 0);
    chk("rst2_freeze", int'(lap_freeze), 0);
    chk("rst2_count_clr", int'(count_clr), 1);
    chk("rst2_tick_out", int'(tick_out), 0);
    chk("rst2_disp_sel", int'(disp_sel), 0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    press(B_SS);
    chk("held_lap_no_event", int'(state), 1);
    chk("held_lap_no_freeze", int'(lap_freeze), 0);
    btns = btns & ~B_LAP;
    repeat (40) @(negedge clk);
    chk("lap_release_state", int'(state), 1);
    press(B_LAP);
    chk("lap_repress_state", int'(state), 3);

    chk("clr_tick_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chronometer_controller.md
# chronometer_controller

Run/pause/lap/clear sequencer for the chronometer's counter chain. It debounces three front-panel buttons and gates the 100 Hz tick into the BCD counter chain. It also issues a clear to that chain, freezes the displayed value during a lap, and drives the LED page select for the 2-input display mux. It sits between the 100 Hz frequency divider and the first decade counter, and it drives the mux address in place of the raw switch.

## Interface
- DEBOUNCE_TICKS, 2: consecutive TICK_100HZ samples a button must hold a new level before it is accepted (range 1..15).
- PAGE_TICKS, 200: TICK_100HZ pulses per display page in auto mode (range 1..1023).

- CLK_50M  input  1  system clock; all logic on its rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- TICK_100HZ  input  1  one-CLK_50M-cycle pulse from the divider, synchronous to CLK_50M.
- BTN_START_STOP  input  1  raw button, active-high, asynchronous.
- BTN_LAP  input  1  raw button, active-high, asynchronous.
- BTN_CLEAR  input  1  raw button, active-high, asynchronous.
- AUTO_PAGE  input  1  1 = DISP_SEL toggles automatically; 0 = DISP_SEL follows MANUAL_SEL.
- MANUAL_SEL  input  1  page select used when AUTO_PAGE=0.
- TICK_OUT  output  1  gated tick to the counter chain.
- COUNT_CLR  output  1  synchronous clear for the counter chain.
- LAP_FREEZE  output  1  1 = display holds its latched value.
- DISP_SEL  output  1  mux address; 0 = centiseconds/tenths byte, 1 = seconds byte.
- STATE  output  2  current FSM state, for debug.

## Operation
- Button path (per button):
  - 2-FF synchronizer, then a debounce counter sampled only on TICK_100HZ.
  - The accepted level changes after DEBOUNCE_TICKS consecutive samples that differ from it. Any sample equal to the accepted level resets the counter.
  - A 0→1 transition of the accepted level produces a one-cycle press event. Release produces no event.
- FSM states and encodings: IDLE=00, RUNNING=01, PAUSED=10, LAP=11.
  - IDLE: start_stop → RUNNING. clear → COUNT_CLR pulse, stay IDLE. lap ignored.
  - RUNNING: start_stop → PAUSED. lap → LAP. clear ignored.
  - LAP: lap → RUNNING. start_stop → PAUSED. clear ignored.
  - PAUSED: start_stop → RUNNING. clear → COUNT_CLR pulse, then IDLE. lap ignored.
- Simultaneous events in one cycle: priority clear > start_stop > lap. Only the highest-priority event that is legal in the current state is acted on. All others in that cycle are dropped, not queued.
- TICK_OUT is TICK_100HZ registered, qualified by state ∈ {RUNNING, LAP}. Counting continues during LAP.
- LAP_FREEZE = 1 exactly while state = LAP.
- COUNT_CLR is a one-cycle pulse and is never asserted in the same cycle as TICK_OUT.
- Page logic:
  - AUTO_PAGE=1: a 10-bit tick counter counts TICK_100HZ pulses. On reaching PAGE_TICKS−1 with a tick, it wraps to 0 and DISP_SEL toggles.
  - AUTO_PAGE=0: the counter is held at 0 and DISP_SEL = MANUAL_SEL, registered.
  - Switching AUTO_PAGE 0→1 starts auto mode from the current DISP_SEL value with the counter at 0.

## Timing
- Reset (RST_N low at a clock edge):
  - STATE=IDLE, TICK_OUT=0, LAP_FREEZE=0, DISP_SEL=0.
  - COUNT_CLR=1 while reset is held, falling to 0 on the first edge with RST_N high. This clears the counter chain, which has no reset of its own.
  - Synchronizers, debounce counters, accepted levels and the page counter all go to 0.
- Reset mid-operation: same values as above. A button still held through reset must be released and re-pressed before it generates an event.
- Press latency: raw edge → synchronized after 2 cycles. Accepted on the DEBOUNCE_TICKS-th qualifying tick. Event pulse in the cycle after acceptance. STATE, LAP_FREEZE and COUNT_CLR update on the next edge.
- TICK_OUT latency: 1 cycle after TICK_100HZ.
  - A tick coinciding with the event that enters RUNNING is not passed.
  - A tick coinciding with the event that leaves RUNNING or LAP is passed.
- DISP_SEL latency:
  - Auto mode: toggles 1 cycle after the PAGE_TICKS-th tick.
  - Manual mode: follows MANUAL_SEL with 1 cycle latency.

## Test plan
Bench settings: DEBOUNCE_TICKS=2, PAGE_TICKS=4, TICK_100HZ every 10 cycles.
- Reset, then release: COUNT_CLR=1 during reset and 0 one cycle after release; STATE=00; TICK_OUT never pulses over 100 cycles.
- Press start_stop and hold for 40 cycles: STATE=01 after debounce; TICK_OUT pulses 1 cycle after each TICK_100HZ. A second press gives STATE=10 and TICK_OUT stays silent.
- Apply a 3-cycle glitch on BTN_LAP while RUNNING: no event, STATE stays 01. A held press gives STATE=11 and LAP_FREEZE=1 while TICK_OUT continues. A second lap press gives STATE=01 and LAP_FREEZE=0.
- In PAUSED, press start_stop and clear in the same cycle: clear wins, giving a one-cycle COUNT_CLR and STATE=00. In RUNNING, the same combination gives STATE=10 with no COUNT_CLR.
- With AUTO_PAGE=1: DISP_SEL toggles every 4 ticks (40 cycles). Dropping AUTO_PAGE with MANUAL_SEL=1 gives DISP_SEL=1 next cycle and the page counter reads 0.
- Assert reset while in LAP with BTN_LAP still held: all outputs return to reset values. No lap event occurs until the button is released and pressed again.
